// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM requesters.
// One transaction in flight at a time; a ROM download suspends all traffic.
module jtframe_sdram_arb #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic [SLOTS-1:0]   slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]   slot_ok,
  output logic [DW-1:0]      slot_dout,
  output logic               sdram_req,
  output logic [AW-1:0]      sdram_addr,
  input  logic               sdram_ack,
  input  logic               data_rdy,
  input  logic [DW-1:0]      data_read,
  output logic               refresh_en,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } state_t;

  state_t            r_state, w_state_nx;
  logic [GW-1:0]     r_ptr, r_gnt, w_ptr_nx, w_gnt_nx, w_pick;
  logic              w_found, w_grant, w_rdy_now;
  logic [SLOTS-1:0]  r_ok, w_ok_nx;
  logic [DW-1:0]     r_dout, w_dout_nx;
  logic              r_req, w_req_nx;
  logic [AW-1:0]     r_addr, w_addr_nx;
  logic              r_refresh, w_refresh_nx;
  logic              r_busy;

  // First requesting slot at or above r_ptr, wrapping modulo SLOTS.
  always_comb begin : pick_p
    logic [GW:0] v_sum;
    v_sum   = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      v_sum = {1'b0, r_ptr} + (GW+1)'(i);
      if (v_sum >= (GW+1)'(SLOTS)) v_sum = v_sum - (GW+1)'(SLOTS);
      if (!w_found && slot_req[v_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = v_sum[GW-1:0];
      end
    end
  end

  assign w_grant = (r_state == ST_IDLE) && w_found && !downloading;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_ok      <= '0;
      r_dout    <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_refresh <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_ptr     <= w_ptr_nx;
      r_gnt     <= w_gnt_nx;
      r_ok      <= w_ok_nx;
      r_dout    <= w_dout_nx;
      r_req     <= w_req_nx;
      r_addr    <= w_addr_nx;
      r_refresh <= w_refresh_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
    end
  end

  // A same-cycle ack+rdy in WAIT_ACK completes the whole transaction at once.
  always_comb begin
    w_state_nx = r_state;
    w_rdy_now  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) w_state_nx = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          if (data_rdy) begin
            w_state_nx = ST_IDLE;
            w_rdy_now  = 1'b1;
          end else begin
            w_state_nx = ST_WAIT_RDY;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (data_rdy) begin
          w_state_nx = ST_IDLE;
          w_rdy_now  = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (downloading) begin
      w_state_nx = ST_IDLE;
      w_rdy_now  = 1'b0;
    end
  end

  always_comb begin
    w_req_nx     = r_req;
    w_addr_nx    = r_addr;
    w_ok_nx      = '0;
    w_dout_nx    = r_dout;
    w_refresh_nx = 1'b0;
    w_gnt_nx     = r_gnt;
    w_ptr_nx     = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_gnt_nx  = w_pick;
          w_addr_nx = slot_addr[int'(w_pick)*AW +: AW];
          w_req_nx  = 1'b1;
        end else begin
          w_refresh_nx = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) w_req_nx = 1'b0;
      end
      default: ;
    endcase
    if (w_rdy_now) begin
      w_dout_nx      = data_read;
      w_ok_nx[r_gnt] = slot_req[r_gnt];
      w_ptr_nx       = (r_gnt == GW'(SLOTS-1)) ? '0 : r_gnt + 1'b1;
    end
    if (downloading) begin
      w_req_nx     = 1'b0;
      w_ok_nx      = '0;
      w_refresh_nx = 1'b1;
      w_ptr_nx     = r_ptr;
    end
  end

  assign slot_ok    = r_ok;
  assign slot_dout  = r_dout;
  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;
  assign refresh_en = r_refresh;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: directed scenarios plus random
// transactions checked against a round-robin reference model.
module tb_jtframe_sdram_arb;
  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               downloading = 1'b0;
  logic [SLOTS-1:0]   slot_req = '0;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]   slot_ok;
  logic [DW-1:0]      slot_dout;
  logic               sdram_req;
  logic [AW-1:0]      sdram_addr;
  logic               sdram_ack = 1'b0;
  logic               data_rdy = 1'b0;
  logic [DW-1:0]      data_read = '0;
  logic               refresh_en;
  logic               busy;
  logic [1:0]         dbg_state;

  logic [AW-1:0]      m_addr [SLOTS];
  logic [DW-1:0]      m_dout;
  int                 m_ptr;
  logic [SLOTS-1:0]   reraise;
  int                 n_checks = 0;
  int                 n_err = 0;

  jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot_req(slot_req), .slot_addr(slot_addr),
    .slot_ok(slot_ok), .slot_dout(slot_dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int s = 0; s < SLOTS; s++) slot_addr[s*AW +: AW] = m_addr[s];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requesting slot searching upward from ptr, wrapping.
  function automatic int exp_grant(input logic [SLOTS-1:0] req, input int ptr);
    for (int i = 0; i < SLOTS; i++)
      if (req[(ptr + i) % SLOTS]) return (ptr + i) % SLOTS;
    return -1;
  endfunction

  // Plays the SDRAM controller for one transaction expected to go to slot exp_g.
  task automatic serve(input int ack_dly, input int rdy_dly, input logic [DW-1:0] data,
                       input int exp_g, input bit drop);
    bit got;
    logic [63:0] exp_ok;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      tick();
      if (n == 0) begin
        check("ok_fall", 64'(slot_ok), 64'(0));
        check("dout_hold", 64'(slot_dout), 64'(m_dout));
        slot_req = slot_req | reraise;
        reraise  = '0;
      end
      if (sdram_req) got = 1'b1;
    end
    check("req_seen", 64'(got), 64'(1));
    if (!got) return;
    check("grant_addr", 64'(sdram_addr), 64'(m_addr[exp_g]));
    check("busy_on", 64'(busy), 64'(1));
    check("refresh_off", 64'(refresh_en), 64'(0));
    repeat (ack_dly) begin
      tick();
      check("req_hold", 64'(sdram_req), 64'(1));
      check("addr_hold", 64'(sdram_addr), 64'(m_addr[exp_g]));
    end
    sdram_ack = 1'b1;
    if (rdy_dly == 0) begin
      data_rdy  = 1'b1;
      data_read = data;
    end
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    check("req_fall", 64'(sdram_req), 64'(0));
    if (rdy_dly > 0) begin
      if (drop) slot_req[2'(exp_g)] = 1'b0;
      check("no_early_ok", 64'(slot_ok), 64'(0));
      repeat (rdy_dly - 1) begin
        tick();
        check("wait_rdy_busy", 64'(busy), 64'(1));
      end
      data_rdy  = 1'b1;
      data_read = data;
      tick();
      data_rdy  = 1'b0;
    end
    exp_ok = (drop && rdy_dly > 0) ? 64'(0) : (64'(1) << exp_g);
    check("slot_ok", 64'(slot_ok), exp_ok);
    check("slot_dout", 64'(slot_dout), 64'(data));
    m_dout = data;
    m_ptr  = (exp_g + 1) % SLOTS;
  endtask

  initial begin
    int g;
    bit drp;
    int ad, rd;
    for (int s = 0; s < SLOTS; s++) m_addr[s] = '0;
    m_dout  = '0;
    m_ptr   = 0;
    reraise = '0;

    // Reset values
    tick(); tick();
    rst = 1'b0;
    check("rst_req", 64'(sdram_req), 64'(0));
    check("rst_addr", 64'(sdram_addr), 64'(0));
    check("rst_ok", 64'(slot_ok), 64'(0));
    check("rst_dout", 64'(slot_dout), 64'(0));
    check("rst_refresh", 64'(refresh_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    tick();
    check("idle_refresh", 64'(refresh_en), 64'(1));

    // Single slot
    m_addr[2] = 22'h01234;
    slot_req  = 4'b0100;
    serve(3, 5, 32'hDEADBEEF, 2, 1'b0);
    slot_req = '0;
    tick();
    check("single_ok_1cyc", 64'(slot_ok), 64'(0));
    check("single_dout_held", 64'(slot_dout), 64'(32'hDEADBEEF));

    // Round robin from a fresh pointer: 0,1,2,3,0
    rst = 1'b1; tick(); rst = 1'b0;
    m_ptr = 0; m_dout = '0;
    for (int s = 0; s < SLOTS; s++) m_addr[s] = 22'(32'h100 * (s + 1));
    slot_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve($urandom_range(0, 2), $urandom_range(1, 3), $urandom, k % SLOTS, 1'b0);
      slot_req = 4'b1111 & ~(4'b0001 << (k % SLOTS));
      reraise  = 4'b0001 << (k % SLOTS);
    end
    reraise = '0;

    // Withdrawn request: slot 1 drops in WAIT_RDY, then slot 2 is next
    slot_req = 4'b0110;
    g = exp_grant(slot_req, m_ptr);
    serve(1, 2, 32'h13572468, g, 1'b1);
    serve(0, 1, 32'h2468ACE0, 2, 1'b0);

    // Same-cycle ack+rdy
    slot_req = 4'b0001;
    serve(2, 0, 32'h0000A5A5, exp_grant(slot_req, m_ptr), 1'b0);

    // Download during WAIT_ACK
    slot_req = 4'b1010;
    g = exp_grant(slot_req, m_ptr);
    tick();
    check("dl_granted", 64'(sdram_req), 64'(1));
    downloading = 1'b1;
    sdram_ack   = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("dl_req", 64'(sdram_req), 64'(0));
    check("dl_refresh", 64'(refresh_en), 64'(1));
    check("dl_busy", 64'(busy), 64'(0));
    data_rdy  = 1'b1;
    data_read = 32'hBADBAD00;
    tick();
    data_rdy = 1'b0;
    check("dl_no_ok", 64'(slot_ok), 64'(0));
    check("dl_no_arb", 64'(sdram_req), 64'(0));
    downloading = 1'b0;
    serve(1, 1, 32'h600DF00D, g, 1'b0);

    // Reset during WAIT_RDY, then a late data_rdy
    slot_req = 4'b0100;
    tick();
    check("rr_granted", 64'(sdram_req), 64'(1));
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("rr_wait_rdy", 64'(dbg_state), 64'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    slot_req = '0;
    check("mid_rst_req", 64'(sdram_req), 64'(0));
    check("mid_rst_addr", 64'(sdram_addr), 64'(0));
    check("mid_rst_dout", 64'(slot_dout), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_refresh", 64'(refresh_en), 64'(0));
    data_rdy  = 1'b1;
    data_read = 32'hFEEDFACE;
    tick();
    data_rdy = 1'b0;
    check("late_rdy_ok", 64'(slot_ok), 64'(0));
    check("late_rdy_dout", 64'(slot_dout), 64'(0));
    m_ptr = 0; m_dout = '0;
    slot_req = 4'b1111;
    serve(0, 1, 32'h0BADC0DE, 0, 1'b0);

    // Random traffic against the round-robin model
    for (int t = 0; t < 30; t++) begin
      slot_req = 4'($urandom_range(1, 15));
      for (int s = 0; s < SLOTS; s++) m_addr[s] = 22'($urandom);
      g   = exp_grant(slot_req, m_ptr);
      ad  = $urandom_range(0, 4);
      rd  = $urandom_range(0, 4);
      drp = ($urandom_range(0, 3) == 0);
      serve(ad, rd, $urandom, g, drp);
    end
    slot_req = '0;
    tick();
    check("final_ok_clear", 64'(slot_ok), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
- Round-robin arbiter that shares the single game-side SDRAM read port between SLOTS ROM requesters (CPU ROM, graphics, sound, etc.).
- Sits between the game's ROM slot logic and the frame's SDRAM controller interface (sdram_req/sdram_addr/sdram_ack/data_rdy/data_read/refresh_en).
- Only one transaction is in flight at a time.
- Blocks all traffic while a ROM download is in progress.

Parameters:
- SLOTS, 4: number of requesters (2..8).
- AW, 22: SDRAM word address width.
- DW, 32: read data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- downloading  in  1  ROM download in progress; suspends arbitration.
- slot_req  in  SLOTS  level request per slot; held until slot_ok or withdrawn.
- slot_addr  in  SLOTS*AW  slot i address at bits [i*AW +: AW].
- slot_ok  out  SLOTS  one-cycle pulse: data for slot i is valid on slot_dout.
- slot_dout  out  DW  last data read; held until next data_rdy.
- sdram_req  out  1  request to SDRAM controller.
- sdram_addr  out  AW  latched address of granted slot.
- sdram_ack  in  1  controller accepted request (one-cycle pulse).
- data_rdy  in  1  data_read valid (one-cycle pulse).
- data_read  in  DW  SDRAM read data.
- refresh_en  out  1  controller may run refresh.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset values:
  - sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, refresh_en=0, busy=0.
  - State=IDLE, priority pointer ptr=0.
- States: IDLE, WAIT_ACK, WAIT_RDY.
- IDLE:
  - If downloading=0 and any slot_req is set, grant the first set slot searching from ptr upward, wrapping modulo SLOTS.
  - On grant: latch gnt=slot index and sdram_addr=slot_addr[gnt], set sdram_req=1, go to WAIT_ACK.
  - A request seen at edge N gives sdram_req=1 after edge N.
  - refresh_en=1 in the cycle after any edge where IDLE has no grant; otherwise refresh_en=0.
- WAIT_ACK:
  - Hold sdram_req and sdram_addr stable.
  - On sdram_ack: sdram_req=0, go to WAIT_RDY.
  - If sdram_ack and data_rdy arrive in the same cycle, treat as ack then rdy: complete directly to IDLE, doing the WAIT_RDY actions that cycle.
- WAIT_RDY:
  - On data_rdy: slot_dout<=data_read.
  - slot_ok[gnt]<=1 for one cycle, only if slot_req[gnt] is still 1 that cycle. Otherwise the data is discarded: no ok pulse, but slot_dout is still updated.
  - ptr<=(gnt+1) mod SLOTS, go to IDLE.
- Re-grant timing: a new grant can be issued on the edge after returning to IDLE. Minimum spacing between sdram_req assertions is 1 idle cycle.
- Fairness: a slot with continuous req is served at most once per SLOTS grants while any other slot is requesting.
- Address changes while granted: sdram_addr is not updated. Requesters must keep their address stable until slot_ok.
- Requester drops slot_req mid-transaction: the transaction completes on the SDRAM side; no slot_ok is given.
- downloading=1:
  - In any state, the next edge forces IDLE with sdram_req=0, slot_ok=0, refresh_en=1.
  - Outstanding ack/rdy are ignored; ptr is unchanged.
  - Arbitration resumes the first cycle downloading=0.
- rst mid-operation: immediate return to reset values on the next edge, regardless of state.
- slot_ok is never set for more than one slot in the same cycle. It is never set unless a data_rdy was received in WAIT_RDY.
- Stray sdram_ack or data_rdy in IDLE is ignored.

Test Plan:
- Single slot: slot_req[2]=1, addr=22'h01234; ack 3 cycles after req, data_rdy 5 cycles after ack with data_read=32'hDEADBEEF -> sdram_addr=22'h01234, sdram_req falls the edge after ack, slot_ok=4'b0100 for exactly 1 cycle, slot_dout=32'hDEADBEEF and held.
- Round robin: slot_req=4'b1111 held, each served slot drops its req for one cycle after ok, then re-raises it -> grant order 0,1,2,3,0; no slot is served twice before all others are served.
- Withdrawn request: slot_req[1] deasserted while in WAIT_RDY -> no slot_ok pulse, slot_dout updated; the next grant goes to slot 2 if requesting.
- Same-cycle ack+rdy with data_read=32'h0000A5A5 -> direct return to IDLE, slot_ok pulse given, slot_dout=32'h0000A5A5.
- downloading raised during WAIT_ACK -> sdram_req=0 and refresh_en=1 the next cycle; no slot_ok; after downloading falls, the pending request is re-granted with ptr unchanged.
- rst pulsed during WAIT_RDY -> all outputs 0 and ptr=0 next cycle; a late data_rdy produces no slot_ok.
